sram_like_axi_bridge_n: RTL and testbench



---
 rtl/sram_like_axi_bridge_n.sv | 225 ++++++++++++++++++++++
 tb/tb_sram_like_axi_bridge_n.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_axi_bridge_n.sv
// N-port sram-like to AXI3 bridge: round-robin arbitration, one outstanding
// single-beat transaction, per-port error reporting alongside data_ok.
module sram_like_axi_bridge_n #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          req,
    input  logic [N_PORTS-1:0]          wr,
    input  logic [2*N_PORTS-1:0]        size,
    input  logic [ADDR_W*N_PORTS-1:0]   addr,
    input  logic [DATA_W*N_PORTS-1:0]   wdata,
    output logic [DATA_W-1:0]           rdata,
    output logic [N_PORTS-1:0]          addr_ok,
    output logic [N_PORTS-1:0]          data_ok,
    output logic [N_PORTS-1:0]          resp_err,
    output logic [ID_W-1:0]             axi_arid,
    output logic [ADDR_W-1:0]           axi_araddr,
    output logic [3:0]                  axi_arlen,
    output logic [2:0]                  axi_arsize,
    output logic [1:0]                  axi_arburst,
    output logic [1:0]                  axi_arlock,
    output logic [3:0]                  axi_arcache,
    output logic [2:0]                  axi_arprot,
    output logic                        axi_arvalid,
    input  logic                        axi_arready,
    input  logic [ID_W-1:0]             axi_rid,
    input  logic [DATA_W-1:0]           axi_rdata,
    input  logic [1:0]                  axi_rresp,
    input  logic                        axi_rlast,
    input  logic                        axi_rvalid,
    output logic                        axi_rready,
    output logic [ID_W-1:0]             axi_awid,
    output logic [ADDR_W-1:0]           axi_awaddr,
    output logic [3:0]                  axi_awlen,
    output logic [2:0]                  axi_awsize,
    output logic [1:0]                  axi_awburst,
    output logic [1:0]                  axi_awlock,
    output logic [3:0]                  axi_awcache,
    output logic [2:0]                  axi_awprot,
    output logic                        axi_awvalid,
    input  logic                        axi_awready,
    output logic [ID_W-1:0]             axi_wid,
    output logic [DATA_W-1:0]           axi_wdata,
    output logic [3:0]                  axi_wstrb,
    output logic                        axi_wlast,
    output logic                        axi_wvalid,
    input  logic                        axi_wready,
    input  logic [ID_W-1:0]             axi_bid,
    input  logic [1:0]                  axi_bresp,
    input  logic                        axi_bvalid,
    output logic                        axi_bready
);

    localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AWW  = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;

    logic [1:0]        size_a  [N_PORTS];
    logic [ADDR_W-1:0] addr_a  [N_PORTS];
    logic [DATA_W-1:0] wdata_a [N_PORTS];
    logic              grant_vld;
    logic [IDX_W-1:0]  grant_idx;
    logic              unused_inputs;

    assign unused_inputs = ^{axi_rid, axi_rlast, axi_bid};

    always_comb begin
        for (int i = 0; i < int'(N_PORTS); i++) begin
            size_a[i]  = size[2*i +: 2];
            addr_a[i]  = addr[ADDR_W*i +: ADDR_W];
            wdata_a[i] = wdata[DATA_W*i +: DATA_W];
        end
    end

    // Round-robin: scan from last+1 upward; the lowest offset wins, so scan downward and overwrite.
    always_comb begin
        int cand;
        cand      = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = int'(N_PORTS); k >= 1; k--) begin
            cand = (int'(last_q) + k) % int'(N_PORTS);
            if (req[IDX_W'(cand)]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_ok   = '0;
        data_ok   = '0;
        resp_err  = '0;
        case (state_q)
            S_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (grant_vld) begin
                    addr_ok = rst ? '0 : (N_PORTS'(1) << grant_idx);
                    owner_d = grant_idx;
                    last_d  = grant_idx;
                    wr_d    = wr[grant_idx];
                    size_d  = size_a[grant_idx];
                    addr_d  = addr_a[grant_idx];
                    wdata_d = wdata_a[grant_idx];
                    state_d = wr[grant_idx] ? S_AWW : S_AR;
                end
            end
            S_AR: begin
                if (axi_arready) state_d = S_R;
            end
            S_R: begin
                if (axi_rvalid) begin
                    data_ok  = N_PORTS'(1) << owner_q;
                    resp_err = (axi_rresp != 2'b00) ? (N_PORTS'(1) << owner_q) : '0;
                    state_d  = S_IDLE;
                end
            end
            S_AWW: begin
                aw_done_d = aw_done_q | axi_awready;
                w_done_d  = w_done_q | axi_wready;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_B;
                end
            end
            S_B: begin
                if (axi_bvalid) begin
                    data_ok  = N_PORTS'(1) << owner_q;
                    resp_err = (axi_bresp != 2'b00) ? (N_PORTS'(1) << owner_q) : '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= IDX_W'(N_PORTS - 1);
            owner_q   <= '0;
            wr_q      <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Byte lanes from access size and the low address bits.
    always_comb begin
        case (size_q)
            2'd0:    axi_wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    axi_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: axi_wstrb = 4'b1111;
        endcase
    end

    assign rdata       = axi_rdata;
    assign axi_arid    = ID_W'(owner_q);
    assign axi_araddr  = addr_q;
    assign axi_arlen   = 4'd0;
    assign axi_arsize  = {1'b0, size_q};
    assign axi_arburst = 2'b01;
    assign axi_arlock  = 2'b00;
    assign axi_arcache = 4'd0;
    assign axi_arprot  = 3'd0;
    assign axi_arvalid = (state_q == S_AR);
    assign axi_rready  = (state_q == S_R);
    assign axi_awid    = ID_W'(owner_q);
    assign axi_awaddr  = addr_q;
    assign axi_awlen   = 4'd0;
    assign axi_awsize  = {1'b0, size_q};
    assign axi_awburst = 2'b01;
    assign axi_awlock  = 2'b00;
    assign axi_awcache = 4'd0;
    assign axi_awprot  = 3'd0;
    assign axi_awvalid = (state_q == S_AWW) && !aw_done_q;
    assign axi_wid     = ID_W'(owner_q);
    assign axi_wdata   = wdata_q;
    assign axi_wlast   = 1'b1;
    assign axi_wvalid  = (state_q == S_AWW) && !w_done_q;
    assign axi_bready  = (state_q == S_B);

endmodule

// File: tb/tb_sram_like_axi_bridge_n.sv
// Bench for sram_like_axi_bridge_n with three ports: directed and randomized
// transactions against a round-robin / byte-lane reference model.
module tb_sram_like_axi_bridge_n;

    localparam int unsigned NP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req, wr;
    logic [5:0]  size;
    logic [95:0] addr, wdata;
    logic [31:0] rdata;
    logic [2:0]  addr_ok, data_ok, resp_err;
    logic [3:0]  axi_arid, axi_arlen, axi_arcache, axi_rid, axi_awid, axi_awlen, axi_awcache, axi_wid, axi_bid, axi_wstrb;
    logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
    logic [2:0]  axi_arsize, axi_arprot, axi_awsize, axi_awprot;
    logic [1:0]  axi_arburst, axi_arlock, axi_rresp, axi_awburst, axi_awlock, axi_bresp;
    logic        axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
    logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready, axi_bvalid, axi_bready;

    int          vectors = 0;
    int          miscompares = 0;
    int          model_last;
    logic        p_wr    [NP];
    logic [1:0]  p_sz    [NP];
    logic [31:0] p_addr  [NP];
    logic [31:0] p_wdata [NP];

    sram_like_axi_bridge_n #(.N_PORTS(NP), .ID_W(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok), .resp_err(resp_err),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wid(axi_wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_port(input int p);
        wr[p]           = p_wr[p];
        size[2*p +: 2]  = p_sz[p];
        addr[32*p +: 32]  = p_addr[p];
        wdata[32*p +: 32] = p_wdata[p];
    endtask

    task automatic rand_port(input int p);
        p_wr[p]    = 1'($urandom_range(0, 1));
        p_sz[p]    = 2'($urandom_range(0, 2));
        p_addr[p]  = $urandom;
        p_wdata[p] = $urandom;
    endtask

    // Round-robin reference: first requester after the previous winner, wrapping.
    function automatic int rr_pick(input logic [2:0] m);
        for (int k = 1; k <= int'(NP); k++) begin
            if (m[(model_last + k) % int'(NP)]) return (model_last + k) % int'(NP);
        end
        return 0;
    endfunction

    // Byte lanes covered by a naturally aligned access of 2**sz bytes.
    function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [1:0] a);
        int n;
        int start;
        logic [3:0] m;
        n = 1 << sz;
        start = (int'(a) / n) * n;
        m = '0;
        for (int b = 0; b < 4; b++) if (b >= start && b < start + n) m[b] = 1'b1;
        return m;
    endfunction

    task automatic txn(input logic [2:0] mask, input logic [1:0] resp, input logic [31:0] rd,
                       input int a_wait, input int w_wait, input int d_wait);
        int g;
        int last_c;
        logic [2:0] oh;
        logic ewr;
        logic [1:0] esz;
        logic [31:0] ea, ewd;
        req = mask;
        for (int p = 0; p < int'(NP); p++) if (mask[p]) drive_port(p);
        g = rr_pick(mask);
        oh = 3'(1 << g);
        ewr = p_wr[g]; esz = p_sz[g]; ea = p_addr[g]; ewd = p_wdata[g];
        #1;
        chk("addr_ok_grant", 32'(addr_ok), 32'(oh));
        chk("data_ok_idle", 32'(data_ok), 32'd0);
        model_last = g;
        tick();
        req[g] = 1'b0;
        wr[g] = ~ewr;
        size[2*g +: 2] = 2'($urandom_range(0, 3));
        addr[32*g +: 32] = $urandom;
        wdata[32*g +: 32] = $urandom;
        if (!ewr) begin
            for (int c = 0; c <= a_wait; c++) begin
                axi_arready = (c == a_wait);
                #1;
                chk("arvalid", 32'(axi_arvalid), 32'd1);
                chk("addr_ok_busy", 32'(addr_ok), 32'd0);
                if (c == 0) begin
                    chk("araddr", axi_araddr, ea);
                    chk("arsize", 32'(axi_arsize), 32'({1'b0, esz}));
                    chk("arid", 32'(axi_arid), g);
                    chk("arlen_arburst", 32'({axi_arlen, axi_arburst}), 32'(6'b0000_01));
                end
                tick();
            end
            axi_arready = 1'b0;
            for (int c = 0; c <= d_wait; c++) begin
                axi_rvalid = (c == d_wait);
                axi_rdata  = (c == d_wait) ? rd : $urandom;
                axi_rresp  = resp;
                #1;
                chk("rready", 32'(axi_rready), 32'd1);
                chk("r_data_ok", 32'(data_ok), (c == d_wait) ? 32'(oh) : 32'd0);
                if (c == d_wait) begin
                    chk("rdata", rdata, rd);
                    chk("r_resp_err", 32'(resp_err), (resp != 2'b00) ? 32'(oh) : 32'd0);
                end
                tick();
            end
            axi_rvalid = 1'b0;
        end else begin
            last_c = (a_wait > w_wait) ? a_wait : w_wait;
            for (int c = 0; c <= last_c; c++) begin
                axi_awready = (c == a_wait);
                axi_wready  = (c == w_wait);
                #1;
                chk("awvalid", 32'(axi_awvalid), (c <= a_wait) ? 32'd1 : 32'd0);
                chk("wvalid", 32'(axi_wvalid), (c <= w_wait) ? 32'd1 : 32'd0);
                chk("bready_early", 32'(axi_bready), 32'd0);
                if (c == 0) begin
                    chk("awaddr", axi_awaddr, ea);
                    chk("awsize", 32'(axi_awsize), 32'({1'b0, esz}));
                    chk("awid", 32'(axi_awid), g);
                    chk("wid", 32'(axi_wid), g);
                    chk("wdata", axi_wdata, ewd);
                    chk("wstrb", 32'(axi_wstrb), 32'(exp_strb(esz, ea[1:0])));
                    chk("wlast_awlen", 32'({axi_wlast, axi_awlen}), 32'(5'b1_0000));
                end
                tick();
            end
            axi_awready = 1'b0;
            axi_wready  = 1'b0;
            for (int c = 0; c <= d_wait; c++) begin
                axi_bvalid = (c == d_wait);
                axi_bresp  = resp;
                #1;
                chk("bready", 32'(axi_bready), 32'd1);
                chk("b_valids_low", 32'({axi_awvalid, axi_wvalid}), 32'd0);
                chk("b_data_ok", 32'(data_ok), (c == d_wait) ? 32'(oh) : 32'd0);
                if (c == d_wait) chk("b_resp_err", 32'(resp_err), (resp != 2'b00) ? 32'(oh) : 32'd0);
                tick();
            end
            axi_bvalid = 1'b0;
        end
        #1;
        chk("post_data_ok", 32'({data_ok, resp_err}), 32'd0);
        chk("post_valids", 32'({axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req = 3'b001; wr = '0; size = '0; addr = '0; wdata = '0;
        axi_arready = 1'b0; axi_rid = '0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 1'b1; axi_rvalid = 1'b0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bid = '0; axi_bresp = '0; axi_bvalid = 1'b0;
        for (int p = 0; p < int'(NP); p++) rand_port(p);
        model_last = int'(NP) - 1;
        repeat (3) tick();
        chk("rst_addr_ok", 32'(addr_ok), 32'd0);
        chk("rst_data_ok", 32'({data_ok, resp_err}), 32'd0);
        chk("rst_valids", 32'({axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready}), 32'd0);
        req = '0;
        rst = 1'b0;
        tick();

        // Single word read on port 0, minimum latency.
        p_wr[0] = 1'b0; p_sz[0] = 2'd2; p_addr[0] = 32'h1FC0_0000;
        txn(3'b001, 2'b00, 32'h2408_0001, 0, 0, 0);

        // Byte write on port 1 at the top lane, B response one cycle late.
        p_wr[1] = 1'b1; p_sz[1] = 2'd0; p_addr[1] = 32'h8000_0003; p_wdata[1] = 32'hAA00_0000;
        txn(3'b010, 2'b00, 32'h0, 0, 0, 1);

        // AW accepted three cycles after W.
        rand_port(0); p_wr[0] = 1'b1;
        txn(3'b001, 2'b00, 32'h0, 3, 0, 0);

        // Read with SLVERR.
        rand_port(2); p_wr[2] = 1'b0;
        txn(3'b100, 2'b10, $urandom, 0, 0, 1);

        // Randomized traffic with random requester sets, delays and responses.
        for (int t = 0; t < 24; t++) begin
            for (int p = 0; p < int'(NP); p++) rand_port(p);
            txn(3'($urandom_range(1, 7)), 2'($urandom_range(0, 3)), $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset while waiting for R.
        rand_port(0); p_wr[0] = 1'b0;
        req = 3'b001; drive_port(0);
        #1;
        chk("mid_addr_ok", 32'(addr_ok), 32'(3'(1 << rr_pick(3'b001))));
        tick();
        req = '0; axi_arready = 1'b1;
        #1;
        chk("mid_arvalid", 32'(axi_arvalid), 32'd1);
        tick();
        axi_arready = 1'b0;
        #1;
        chk("mid_rready", 32'(axi_rready), 32'd1);
        req = 3'b111;
        rst = 1'b1;
        #1;
        chk("abort_valids", 32'({axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready}), 32'd0);
        chk("abort_ok", 32'({addr_ok, data_ok}), 32'd0);
        model_last = int'(NP) - 1;
        tick();
        chk("abort_hold", 32'({addr_ok, data_ok, axi_arvalid}), 32'd0);
        rst = 1'b0;

        // All ports requesting continuously: strict rotation from port 0.
        for (int t = 0; t < 6; t++) begin
            for (int p = 0; p < int'(NP); p++) rand_port(p);
            txn(3'b111, 2'b00, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
